mips_instr_encoder: RTL and testbench

- Inverse of the MIPS control/ALU decode path: turns a symbolic operation request (ADD, ADDU, SUB, SUBU, AND, OR, SLL, SRL, SLT, ADDI, LW, SW, BEQ, BNE, J) plus operand fields into a 32-bit MIPS instruction word.
- Assigns each accepted word a sequential byte address from an internal program counter.
- Turns absolute branch and jump targets into PC-relative and region-relative fields, and rejects illegal requests.
- Feeds instruction-memory loaders and self-checking benches through a valid/ready output FIFO.

---
 rtl/mips_instr_encoder.sv | 219 +++++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS operation requests into 32-bit instruction words, tags each
// with a sequential byte address and buffers the results in a valid/ready output FIFO.
module mips_instr_encoder #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_base_load,
    input  logic [31:0]          i_base_addr,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [3:0]           i_op_sel,
    input  logic [4:0]           i_rs,
    input  logic [4:0]           i_rt,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_shamt,
    input  logic [15:0]          i_imm,
    input  logic [31:0]          i_target,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [31:0]          o_out_instr,
    output logic [31:0]          o_out_addr,
    output logic                 o_err_pulse,
    output logic [1:0]           o_err_code,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int             AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] sh,
                                            input logic [5:0] funct);
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    logic [31:0]          r_pc;
    logic [31:0]          r_mem_instr [FIFO_DEPTH];
    logic [31:0]          r_mem_addr  [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [31:0]          r_out_instr;
    logic [31:0]          r_out_addr;
    logic                 r_err_pulse;
    logic [1:0]           r_err_code;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [31:0]          w_pc_eff;
    logic [31:0]          w_pc4;
    logic [32:0]          w_diff;
    logic signed [32:0]   w_off;
    logic                 w_br_bad;
    logic                 w_j_bad;
    logic [31:0]          w_instr;
    logic                 w_rej;
    logic [1:0]           w_code;
    logic                 w_acc;
    logic                 w_push;
    logic                 w_pop;
    logic [CW-1:0]        w_count_nxt;
    logic [AW-1:0]        w_rptr_nxt;
    logic [31:0]          w_head_instr;
    logic [31:0]          w_head_addr;

    assign w_pc_eff = i_base_load ? i_base_addr : r_pc;
    assign w_pc4    = w_pc_eff + 32'd4;
    // Branch offset: the 33-bit difference is kept so out-of-range targets are detectable.
    assign w_diff   = {1'b0, i_target} - {1'b0, w_pc4};
    assign w_off    = $signed(w_diff) >>> 2;
    assign w_br_bad = (i_target[1:0] != 2'b00) || (w_off[32:15] != {18{w_off[15]}});
    assign w_j_bad  = (i_target[1:0] != 2'b00) || (i_target[31:28] != w_pc4[31:28]);

    // Combinational encoder and rejection decision.
    always_comb begin
        w_instr = 32'h0000_0000;
        w_rej   = 1'b0;
        w_code  = 2'd0;
        case (i_op_sel)
            4'd0:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h20);
            4'd1:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h21);
            4'd2:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h22);
            4'd3:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h23);
            4'd4:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h24);
            4'd5:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h25);
            4'd6:  w_instr = f_rtype(5'd0, i_rt, i_rd, i_shamt, 6'h00);
            4'd7:  w_instr = f_rtype(5'd0, i_rt, i_rd, i_shamt, 6'h02);
            4'd8:  w_instr = f_rtype(i_rs, i_rt, i_rd, 5'd0, 6'h2A);
            4'd9:  w_instr = {6'h08, i_rs, i_rt, i_imm};
            4'd10: w_instr = {6'h23, i_rs, i_rt, i_imm};
            4'd11: w_instr = {6'h2B, i_rs, i_rt, i_imm};
            4'd12, 4'd13: begin
                if (w_br_bad) begin
                    w_rej  = 1'b1;
                    w_code = 2'd2;
                end else begin
                    w_instr = {((i_op_sel == 4'd12) ? 6'h04 : 6'h05), i_rs, i_rt, w_off[15:0]};
                end
            end
            4'd14: begin
                if (w_j_bad) begin
                    w_rej  = 1'b1;
                    w_code = 2'd3;
                end else begin
                    w_instr = {6'h02, i_target[27:2]};
                end
            end
            default: begin
                w_rej  = 1'b1;
                w_code = 2'd1;
            end
        endcase
    end

    assign w_acc      = i_in_valid && (r_count < DEPTH_C);
    assign w_push     = w_acc && !w_rej;
    assign w_pop      = (r_count != {CW{1'b0}}) && i_out_ready;
    assign w_rptr_nxt = w_pop ? (r_rptr + AW'(1)) : r_rptr;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Next head entry; bypasses the array when the head slot is the one being written now.
    always_comb begin
        if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head_instr = w_instr;
            w_head_addr  = w_pc_eff;
        end else begin
            w_head_instr = r_mem_instr[w_rptr_nxt];
            w_head_addr  = r_mem_addr[w_rptr_nxt];
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= w_instr;
            r_mem_addr[r_wptr]  <= w_pc_eff;
        end
    end

    // Program counter, FIFO control and registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_ADDR;
            r_wptr      <= {AW{1'b0}};
            r_rptr      <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0000_0000;
            r_out_addr  <= 32'h0000_0000;
        end else begin
            if (w_push) begin
                r_pc <= w_pc4;
            end else if (i_base_load) begin
                r_pc <= i_base_addr;
            end else begin
                r_pc <= r_pc;
            end
            r_wptr      <= w_push ? (r_wptr + AW'(1)) : r_wptr;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < DEPTH_C);
            r_out_valid <= (w_count_nxt != {CW{1'b0}});
            if (w_count_nxt != {CW{1'b0}}) begin
                r_out_instr <= w_head_instr;
                r_out_addr  <= w_head_addr;
            end else begin
                r_out_instr <= r_out_instr;
                r_out_addr  <= r_out_addr;
            end
        end
    end

    // Error reporting: pulse, sticky reason code and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'd0;
            r_err_count <= {ERR_CNT_W{1'b0}};
        end else begin
            r_err_pulse <= w_acc && w_rej;
            if (w_acc && w_rej) begin
                r_err_code <= w_code;
                if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end else begin
                    r_err_count <= r_err_count;
                end
            end else begin
                r_err_code  <= r_err_code;
                r_err_count <= r_err_count;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_instr = r_out_instr;
    assign o_out_addr  = r_out_addr;
    assign o_err_pulse = r_err_pulse;
    assign o_err_code  = r_err_code;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: expected words are queued when a request
// is accepted and compared against the FIFO head when the DUT pops it.
module tb_mips_instr_encoder;

    localparam int ERR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_base_load = 1'b0;
    logic [31:0]       i_base_addr = 32'h0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [3:0]        i_op_sel = 4'd0;
    logic [4:0]        i_rs = 5'd0, i_rt = 5'd0, i_rd = 5'd0, i_shamt = 5'd0;
    logic [15:0]       i_imm = 16'h0;
    logic [31:0]       i_target = 32'h0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic [31:0]       o_out_instr;
    logic [31:0]       o_out_addr;
    logic              o_err_pulse;
    logic [1:0]        o_err_code;
    logic [ERR_W-1:0]  o_err_count;

    mips_instr_encoder #(.FIFO_DEPTH(2), .RESET_ADDR(32'h0), .ERR_CNT_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_base_load(i_base_load), .i_base_addr(i_base_addr),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_op_sel(i_op_sel),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .i_imm(i_imm),
        .i_target(i_target), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_instr(o_out_instr), .o_out_addr(o_out_addr), .o_err_pulse(o_err_pulse),
        .o_err_code(o_err_code), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_pc = 32'h0;
    int          m_errcnt = 0;
    logic [1:0]  m_code = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the instruction-set tables.
    function automatic void model(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                                  input logic [31:0] tgt, input logic [31:0] pc,
                                  output logic [31:0] w, output logic [1:0] code);
        logic [31:0]        pc4;
        logic signed [63:0] d;
        logic signed [63:0] off;
        logic [5:0]         funct [9];
        funct = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A};
        pc4  = pc + 32'd4;
        w    = 32'h0;
        code = 2'd0;
        if (op <= 4'd8) begin
            if (op == 4'd6 || op == 4'd7) w = {6'd0, 5'd0, rt, rd, sh, funct[op]};
            else                          w = {6'd0, rs, rt, rd, 5'd0, funct[op]};
        end else if (op == 4'd9)  w = {6'h08, rs, rt, imm};
        else if (op == 4'd10)     w = {6'h23, rs, rt, imm};
        else if (op == 4'd11)     w = {6'h2B, rs, rt, imm};
        else if (op == 4'd12 || op == 4'd13) begin
            d   = $signed({32'd0, tgt}) - $signed({32'd0, pc4});
            off = d >>> 2;
            if (tgt[1:0] != 2'b00 || off < -64'sd32768 || off > 64'sd32767) code = 2'd2;
            else w = {(op == 4'd12) ? 6'h04 : 6'h05, rs, rt, off[15:0]};
        end else if (op == 4'd14) begin
            if (tgt[1:0] != 2'b00 || tgt[31:28] != pc4[31:28]) code = 2'd3;
            else w = {6'h02, tgt[27:2]};
        end else code = 2'd1;
    endfunction

    // Drives one request, waits (bounded) for acceptance and updates the model.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] tgt, input logic bl, input logic [31:0] ba);
        logic [31:0] w;
        logic [31:0] pc_eff;
        logic [1:0]  code;
        int          n;
        i_op_sel = op; i_rs = rs; i_rt = rt; i_rd = rd; i_shamt = sh; i_imm = imm;
        i_target = tgt; i_base_load = bl; i_base_addr = ba; i_in_valid = 1'b1;
        n = 0;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            check("in_ready_timeout", 32'(o_in_ready), 32'd1);
            i_in_valid = 1'b0;
            i_base_load = 1'b0;
            return;
        end
        pc_eff = bl ? ba : m_pc;
        model(op, rs, rt, rd, sh, imm, tgt, pc_eff, w, code);
        if (code != 2'd0) begin
            m_pc   = pc_eff;
            m_code = code;
            if (m_errcnt < 255) m_errcnt++;
        end else begin
            sb.push_back('{instr: w, addr: pc_eff});
            m_pc = pc_eff + 32'd4;
        end
        @(negedge clk);
        i_in_valid = 1'b0;
        i_base_load = 1'b0;
    endtask

    task automatic chk_err(input string tag);
        check({tag, "_pulse"}, 32'(o_err_pulse), 32'd1);
        check({tag, "_code"}, 32'(o_err_code), 32'(m_code));
        check({tag, "_count"}, 32'(o_err_count), 32'(m_errcnt));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: compares each popped head against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", o_out_instr, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                check("instr", o_out_instr, e.instr);
                check("addr", o_out_addr, e.addr);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_out_instr", o_out_instr, 32'h0);
        check("rst_out_addr", o_out_addr, 32'h0);
        check("rst_err_pulse", 32'(o_err_pulse), 32'd0);
        check("rst_err_code", 32'(o_err_code), 32'd0);
        check("rst_err_count", 32'(o_err_count), 32'd0);
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ADD with latency check, then head holds once drained
        i_out_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        check("lat_out_valid", 32'(o_out_valid), 32'd1);
        check("add_word", o_out_instr, 32'h0022_1820);
        drain();
        check("hold_valid", 32'(o_out_valid), 32'd0);
        check("hold_instr", o_out_instr, 32'h0022_1820);

        // LW then SLL with nonzero rs input
        send(4'd10, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 32'h0, 1'b1, 32'h0);
        send(4'd6, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 32'h0, 1'b0, 32'h0);
        drain();

        // base_load together with a backward BEQ
        send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0000_0008, 1'b1, 32'h0000_0010);
        drain();

        // J in region, then J across region; PC must stay put
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0040_0010, 1'b1, 32'h0040_0000);
        send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 1'b0, 32'h0);
        chk_err("j_region");
        @(negedge clk);
        check("err_pulse_one_cycle", 32'(o_err_pulse), 32'd0);
        send(4'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        drain();

        // Other opcodes, random fields
        for (int op = 1; op <= 11; op++) begin
            send(4'(op), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 32'h0, 1'b0, 32'h0);
        end
        send(4'd13, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0, m_pc + 32'h0002_0000, 1'b0, 32'h0);
        send(4'd12, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0, 32'h0000_0011, 1'b0, 32'h0);
        chk_err("br_align");
        drain();

        // Backpressure: third request must wait until a pop frees a slot
        i_out_ready = 1'b0;
        send(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 32'h0, 1'b1, 32'h0);
        send(4'd0, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        check("full_in_ready", 32'(o_in_ready), 32'd0);
        fork
            begin
                repeat (3) @(negedge clk);
                check("held_in_ready", 32'(o_in_ready), 32'd0);
                i_out_ready = 1'b1;
            end
            send(4'd0, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        join
        drain();

        // Illegal op, then out-of-range BNE: no FIFO writes
        send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        chk_err("illegal");
        send(4'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0004_0004, 1'b1, 32'h0);
        chk_err("bne_range");
        check("rej_out_valid", 32'(o_out_valid), 32'd0);

        // Error counter saturation
        for (int k = 0; k < 260; k++) begin
            send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        end
        check("err_sat", 32'(o_err_count), 32'd255);

        // Reset with a full FIFO discards contents immediately
        i_out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        send(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        check("prerst_valid", 32'(o_out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_out_valid), 32'd0);
        check("midrst_in_ready", 32'(o_in_ready), 32'd1);
        check("midrst_err_count", 32'(o_err_count), 32'd0);
        sb.delete();
        m_pc = 32'h0;
        m_errcnt = 0;
        m_code = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        send(4'd5, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 32'h0, 1'b0, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
